// File: rtl/rect_fill.sv
// rect_fill: streams one raster frame of RGB565 pixels per trigger, a solid
// rectangle over a constant background, through a fifo_write/fifo_full handshake.
module rect_fill #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger_i,
  input  logic [11:0] x0_i,
  input  logic [11:0] x1_i,
  input  logic [11:0] y0_i,
  input  logic [11:0] y1_i,
  input  logic [15:0] color_i,
  input  logic        fifo_full_i,
  output logic        fifo_write_o,
  output logic [15:0] fifo_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);
  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_END  = 12'(V_ACTIVE);
  typedef enum logic {IDLE, FILL} state_t;
  state_t      state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [11:0] sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
  logic [15:0] scol_q, scol_d, data_q, data_d;
  logic        write_q, write_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic        in_rect;
  assign in_rect = (x_q >= sx0_q) && (x_q <= sx1_q) && (y_q >= sy0_q) && (y_q <= sy1_q);
  // y reaching V_ACTIVE marks the final pixel as written; that cycle closes the frame
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sx0_d   = sx0_q;
    sx1_d   = sx1_q;
    sy0_d   = sy0_q;
    sy1_d   = sy1_q;
    scol_d  = scol_q;
    data_d  = data_q;
    write_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    if (state_q == IDLE) begin
      x_d = '0;
      y_d = '0;
      if (trigger_i) begin
        sx0_d   = x0_i;
        sx1_d   = x1_i;
        sy0_d   = y0_i;
        sy1_d   = y1_i;
        scol_d  = color_i;
        state_d = FILL;
        busy_d  = 1'b1;
      end
    end else begin
      ovr_d = trigger_i;
      if (y_q == Y_END) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        x_d     = '0;
        y_d     = '0;
      end else if (!fifo_full_i) begin
        write_d = 1'b1;
        data_d  = in_rect ? scol_q : BG_COLOR;
        x_d     = (x_q == X_LAST) ? 12'd0 : x_q + 12'd1;
        y_d     = (x_q == X_LAST) ? y_q + 12'd1 : y_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sx0_q   <= '0;
      sx1_q   <= '0;
      sy0_q   <= '0;
      sy1_q   <= '0;
      scol_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sx0_q   <= sx0_d;
      sx1_q   <= sx1_d;
      sy0_q   <= sy0_d;
      sy1_q   <= sy1_d;
      scol_q  <= scol_d;
      data_q  <= data_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
  assign fifo_write_o = write_q;
  assign fifo_data_o  = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: table-driven and randomized frame checks of rect_fill on an 8x4 frame.
module tb_rect_fill;
  localparam int          H  = 8;
  localparam int          V  = 4;
  localparam logic [15:0] BG = 16'h0000;
  logic        clk = 1'b0, rst_n = 1'b1, trigger_i = 1'b0, fifo_full_i = 1'b0;
  logic [11:0] x0_i = '0, x1_i = '0, y0_i = '0, y1_i = '0;
  logic [15:0] color_i = '0;
  logic        fifo_write_o, busy_o, done_o, overrun_o;
  logic [15:0] fifo_data_o;
  int checks = 0, errors = 0;
  typedef struct {
    logic [11:0] x0, x1, y0, y1;
    logic [15:0] color;
    bit          bp;
    int          ncol;
  } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  rect_fill #(.H_ACTIVE(H), .V_ACTIVE(V), .BG_COLOR(BG)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_i(trigger_i),
    .x0_i(x0_i), .x1_i(x1_i), .y0_i(y0_i), .y1_i(y1_i), .color_i(color_i),
    .fifo_full_i(fifo_full_i), .fifo_write_o(fifo_write_o), .fifo_data_o(fifo_data_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  function automatic logic [15:0] ref_pix(input vec_t v, input int x, input int y);
    return (x >= int'(v.x0) && x <= int'(v.x1) && y >= int'(v.y0) && y <= int'(v.y1)) ? v.color : BG;
  endfunction
  task automatic start(input vec_t v);
    @(negedge clk);
    x0_i = v.x0; x1_i = v.x1; y0_i = v.y0; y1_i = v.y1; color_i = v.color;
    trigger_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    chk("busy_rise", int'(busy_o), 1);
  endtask
  task automatic run_frame(input vec_t v, input int chg_at, input int trig_at);
    logic [15:0] q[$];
    int c = 0, last_wr = -1, done_c = -1, busy_cnt = 0, ov_cnt = 0, ov_c = -1, trig_c = -100;
    int viol = 0, ncol = 0, extra = 0;
    bit done_seen = 0;
    start(v);
    while (c < 1000 && !done_seen) begin
      trigger_i = 1'b0;
      if (fifo_write_o && fifo_full_i) viol++;
      if (busy_o) busy_cnt++;
      if (overrun_o) begin ov_cnt++; ov_c = c; end
      if (done_o) begin done_seen = 1; done_c = c; end
      if (fifo_write_o) begin
        q.push_back(fifo_data_o);
        last_wr = c;
        if (q.size() == chg_at) begin x0_i = 12'd0; x1_i = 12'(H - 1); color_i = ~v.color; end
        if (q.size() == trig_at) begin trigger_i = 1'b1; trig_c = c; end
      end
      fifo_full_i = (v.bp && !fifo_full_i) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      c++;
    end
    trigger_i = 1'b0;
    fifo_full_i = 1'b0;
    chk("done_seen", int'(done_seen), 1);
    chk("n_writes", q.size(), H * V);
    foreach (q[i]) begin
      chk($sformatf("pix%0d", i), int'(q[i]), int'(ref_pix(v, i % H, i / H)));
      if (q[i] == v.color && v.color != BG) ncol++;
    end
    chk("n_color", ncol, v.ncol);
    chk("write_after_full", viol, 0);
    chk("done_latency", done_c - last_wr, 1);
    if (!v.bp) chk("busy_cycles", busy_cnt, H * V + 1);
    if (trig_at >= 0) begin
      chk("overrun_cnt", ov_cnt, 1);
      chk("overrun_latency", ov_c - trig_c, 1);
    end else chk("overrun_cnt", ov_cnt, 0);
    repeat (40) begin
      if (fifo_write_o || busy_o || done_o) extra++;
      @(negedge clk);
    end
    chk("no_second_frame", extra, 0);
  endtask
  initial begin
    vec_t r;
    int wr, cyc, dn;
    tbl[0] = '{12'd2, 12'd4, 12'd1, 12'd2, 16'hF800, 1'b0, 6};
    tbl[1] = '{12'd2, 12'd4, 12'd1, 12'd2, 16'hF800, 1'b1, 6};
    tbl[2] = '{12'd5, 12'd3, 12'd1, 12'd2, 16'hF800, 1'b0, 0};
    tbl[3] = '{12'd0, 12'd4095, 12'd0, 12'd4095, 16'hFFFF, 1'b0, 32};
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", int'({fifo_write_o, fifo_data_o, busy_o, done_o, overrun_o}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_frame(tbl[i], -1, -1);
    run_frame(tbl[0], 5, 10);
    // abort a frame mid-way with reset, then a clean frame must start at (0,0)
    start(tbl[0]);
    wr = 0; cyc = 0;
    while (wr < 15 && cyc < 200) begin
      if (fifo_write_o) wr++;
      if (wr < 15) @(negedge clk);
      cyc++;
    end
    chk("pre_reset_writes", wr, 15);
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({fifo_write_o, fifo_data_o, busy_o, done_o, overrun_o}), 0);
    @(negedge clk);
    chk("held_reset_outputs", int'({fifo_write_o, fifo_data_o, busy_o, done_o, overrun_o}), 0);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o || busy_o || fifo_write_o) dn++;
    end
    chk("aborted_quiet", dn, 0);
    run_frame(tbl[0], -1, -1);
    for (int k = 0; k < 8; k++) begin
      r.x0 = 12'($urandom_range(0, 10));
      r.x1 = ($urandom_range(0, 3) == 0) ? 12'd4095 : 12'($urandom_range(0, 10));
      r.y0 = 12'($urandom_range(0, 5));
      r.y1 = 12'($urandom_range(0, 5));
      r.color = 16'($urandom_range(1, 16'hFFFF));
      r.bp = 1'($urandom_range(0, 1));
      r.ncol = 0;
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          if (ref_pix(r, x, y) == r.color) r.ncol++;
      run_frame(r, -1, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rect_fill.md
# rect_fill

Frame-rate pixel source that feeds the VGA generator's pixel FIFO in place of, or alongside, the line generator. On each frame trigger from the VGA block it streams one full frame of 16-bit RGB565 pixels in raster order: a solid rectangle of a programmable colour over a constant background. It sits directly upstream of the vga block, on the system clock domain, and uses the same fifo_write/fifo_full/fifo_data handshake.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BG_COLOR, 16'h0000, RGB565 background colour
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- trigger  input  1  one-cycle frame start request (vtrigger from vga)
- x0, x1  input  12  rectangle left/right column, inclusive
- y0, y1  input  12  rectangle top/bottom line, inclusive
- color  input  16  RGB565 rectangle colour
- fifo_full  input  1  FIFO cannot accept more words; one entry of slack guaranteed
- fifo_write  output  1  registered write strobe
- fifo_data  output  16  registered pixel word, valid when fifo_write=1
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after last pixel of a frame written
- overrun  output  1  one-cycle pulse when trigger arrives while busy

## Operation
- States: IDLE, FILL.
- IDLE: x=0, y=0, fifo_write=0. trigger=1 → latch x0,x1,y0,y1,color into shadow registers; go FILL; busy=1.
- FILL, each cycle: if fifo_full=0 → fifo_write<=1, fifo_data<=pixel(x,y), advance position; else fifo_write<=0, position held.
- pixel(x,y) = color if x0<=x<=x1 and y0<=y<=y1 (unsigned 12-bit compares on shadow values), else BG_COLOR.
- Advance: x<H_ACTIVE-1 → x+1; else x=0 and y+1. Write of (H_ACTIVE-1, V_ACTIVE-1) → next state IDLE, done<=1 for one cycle, busy<=0.
- Exactly H_ACTIVE*V_ACTIVE writes per trigger, raster order, no gaps except while fifo_full=1.
- Degenerate rectangle (x0>x1 or y0>y1) → whole frame BG_COLOR. Coordinates beyond the active area are clipped naturally.
- Inputs x0..color changing mid-frame have no effect; shadows update only at frame start.
- trigger while in FILL: ignored for the frame, overrun<=1 one cycle, current frame continues.
- trigger on the same edge as the last write: counts as busy → overrun; no new frame.
- Reset (asserted any time, including mid-frame): immediately IDLE, x=y=0, fifo_write=0, fifo_data=0, busy=0, done=0, overrun=0, shadow registers 0. Partial frame abandoned; no done pulse.

## Timing
- All outputs registered; reset values all 0.
- trigger sampled at edge N → busy=1 after N; first fifo_write=1 (pixel 0,0) after N+1 if fifo_full=0 at N+1.
- fifo_full sampled at edge M suppresses the write after M; at most one write follows the FIFO reaching its threshold (covered by slack).
- Throughput: one pixel per clock while fifo_full=0.
- done and busy=0 appear at the edge following the final write edge, i.e. the cycle after the last fifo_write=1.
- Minimum trigger-to-trigger period with no backpressure: H_ACTIVE*V_ACTIVE+2 cycles.

## Test plan
- H_ACTIVE=8, V_ACTIVE=4, x0=2,x1=4,y0=1,y1=2, color=16'hF800, BG=0, fifo_full=0, one trigger → 32 consecutive writes; words 10-12 and 18-20 =16'hF800, others 0; done one cycle after write 32; busy high for 33 cycles.
- Same setup, fifo_full toggled 1-cycle on/1-cycle off pseudo-randomly → still exactly 32 writes, identical data sequence, no write on a cycle following a full=1 sample.
- x0=5,x1=3 → all 32 words =BG_COLOR; done pulses normally.
- Second trigger at write 10 and x0/color changed at write 5 → overrun pulse one cycle after that trigger, frame completes with original rectangle, no second frame starts.
- reset driven low at write 15 for 1 cycle, then trigger → all outputs 0 during reset; new frame restarts at pixel (0,0), 32 writes, no done for the aborted frame.
- Rectangle x0=0,x1=4095,y0=0,y1=4095, color=16'hFFFF → all 32 words 16'hFFFF (clipping).
